// File: rtl/uart_pkg.sv
// Shared UART constants and state encoding, used by both the transmitter and the receiver.
package uart_pkg;
  localparam int OVERSAMPLE = 16;
  localparam int MID_SAMPLE = 7;
  localparam int DATA_BITS  = 8;
  localparam int FRAME_BITS = 11;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_state_t;
endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the asynchronous serial line; both flops reset to the idle level (1).
module uart_rx_sync (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);
  logic meta;

  always_ff @(posedge clk) begin
    if (!reset) begin
      meta <= 1'b1;
      q    <= 1'b1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end
endmodule

// File: rtl/uart_rx.sv
// 16x-oversampled UART receiver: start, 8 data LSB first, parity, stop; one-cycle valid per frame.
// Parity checking is compiled in only when UART_RX_PARITY_CHECK_EN is defined; otherwise parity_err is 0.
module uart_rx
  import uart_pkg::*;
#(
  parameter bit PARITY_ODD = 1'b0
) (
  input  logic                 baud_clk,
  input  logic                 reset,
  input  logic                 rx_in,
  output logic [DATA_BITS-1:0] dout,
  output logic                 parity_out,
  output logic                 valid,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 busy
);
  localparam logic [3:0] MID_CNT  = 4'(MID_SAMPLE);
  localparam logic [3:0] LAST_CNT = 4'(OVERSAMPLE - 1);
  localparam logic [2:0] LAST_IDX = 3'(DATA_BITS - 1);

  uart_state_t          state;
  logic [3:0]           cnt;
  logic [2:0]           idx;
  logic [DATA_BITS-1:0] shreg;
  logic                 par_bit;
  logic                 rx_s;

  uart_rx_sync u_sync (
    .clk   (baud_clk),
    .reset (reset),
    .d     (rx_in),
    .q     (rx_s)
  );

`ifndef UART_RX_PARITY_CHECK_EN
  logic unused_parity_odd;
  assign unused_parity_odd = PARITY_ODD;
`endif

  always_ff @(posedge baud_clk) begin
    if (!reset) begin
      state      <= IDLE;
      cnt        <= 4'd0;
      idx        <= 3'd0;
      shreg      <= '0;
      par_bit    <= 1'b0;
      dout       <= '0;
      parity_out <= 1'b0;
      valid      <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      busy       <= 1'b0;
    end else begin
      valid <= 1'b0;
      case (state)
        IDLE: begin
          cnt <= 4'd0;
          idx <= 3'd0;
          if (!rx_s) begin
            state <= START;
            busy  <= 1'b1;
          end
        end
        START: begin
          // Re-check the line at mid start bit to reject glitches.
          if (cnt == MID_CNT) begin
            cnt <= 4'd0;
            if (!rx_s) begin
              state <= DATA;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        DATA: begin
          cnt <= cnt + 4'd1;
          if (cnt == LAST_CNT) begin
            shreg <= {rx_s, shreg[DATA_BITS-1:1]};
            idx   <= idx + 3'd1;
            if (idx == LAST_IDX) state <= PARITY;
          end
        end
        PARITY: begin
          cnt <= cnt + 4'd1;
          if (cnt == LAST_CNT) begin
            par_bit <= rx_s;
            state   <= STOP;
          end
        end
        STOP: begin
          cnt <= cnt + 4'd1;
          // Leave at mid stop bit so a directly following start bit is caught.
          if (cnt == LAST_CNT) begin
            dout       <= shreg;
            parity_out <= par_bit;
            frame_err  <= ~rx_s;
`ifdef UART_RX_PARITY_CHECK_EN
            parity_err <= (par_bit != (^shreg ^ PARITY_ODD));
`else
            parity_err <= 1'b0;
`endif
            valid      <= 1'b1;
            busy       <= 1'b0;
            state      <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_uart_rx.sv
// Randomized bench for uart_rx: frames are driven bit-serially and the received stream is compared with a frame-level model.
module tb_uart_rx;
  logic       clk;
  logic       reset;
  logic       rx_in;
  logic [7:0] dout;
  logic       parity_out;
  logic       valid;
  logic       parity_err;
  logic       frame_err;
  logic       busy;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  typedef struct {
    logic [7:0] d;
    logic       p;
    logic       fe;
    logic       pe;
    int         t;
  } rec_t;

  rec_t exp_q[$];
  rec_t got_q[$];

  uart_rx #(.PARITY_ODD(1'b0)) dut (
    .baud_clk   (clk),
    .reset      (reset),
    .rx_in      (rx_in),
    .dout       (dout),
    .parity_out (parity_out),
    .valid      (valid),
    .parity_err (parity_err),
    .frame_err  (frame_err),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (valid) got_q.push_back('{d: dout, p: parity_out, fe: frame_err, pe: parity_err, t: cyc});
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic exp_perr(input logic [7:0] d, input logic p);
`ifdef UART_RX_PARITY_CHECK_EN
    return p != ($countones(d) % 2 == 1);
`else
    return 1'b0;
`endif
  endfunction

  // Called at a negedge; the next posedge samples the start bit, and valid shows 171 negedges later.
  task automatic send_frame(input logic [7:0] d, input logic p, input logic s);
    logic [10:0] bits;
    bits = {s, p, d, 1'b0};
    exp_q.push_back('{d: d, p: p, fe: ~s, pe: exp_perr(d, p), t: cyc + 171});
    for (int i = 0; i < 11; i++) begin
      rx_in = bits[i];
      repeat (16) @(negedge clk);
    end
  endtask

  task automatic idle(input int n);
    rx_in = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic check_frames(input string tag);
    int n;
    idle(30);
    chk({tag, "_nvalid"}, got_q.size(), exp_q.size());
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      chk({tag, "_dout"},       got_q[i].d,  exp_q[i].d);
      chk({tag, "_parity_out"}, got_q[i].p,  exp_q[i].p);
      chk({tag, "_frame_err"},  got_q[i].fe, exp_q[i].fe);
      chk({tag, "_parity_err"}, got_q[i].pe, exp_q[i].pe);
      chk({tag, "_valid_time"}, got_q[i].t,  exp_q[i].t);
    end
    got_q.delete();
    exp_q.delete();
  endtask

  initial begin
    reset = 1'b0;
    rx_in = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_dout", dout, 8'h00);
    chk("rst_valid", valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_flags", {parity_out, parity_err, frame_err}, 3'b000);
    reset = 1'b1;
    idle(10);

    send_frame(8'hA5, 1'b0, 1'b1);
    check_frames("a5");

    send_frame(8'h3C, 1'b1, 1'b1);
    check_frames("3c_badpar");

    send_frame(8'h5A, 1'b0, 1'b0);
    idle(20);
    send_frame(8'h01, 1'b1, 1'b1);
    check_frames("stop_err");

    // 4-tick glitch: edges 0..3 see the line low.
    rx_in = 1'b0;
    repeat (4) @(negedge clk);
    rx_in = 1'b1;
    repeat (2) @(negedge clk);
    chk("glitch_busy_hi", busy, 1'b1);
    repeat (6) @(negedge clk);
    chk("glitch_busy_lo", busy, 1'b0);
    idle(200);
    check_frames("glitch");

    send_frame(8'h00, 1'b0, 1'b1);
    send_frame(8'hFF, 1'b0, 1'b1);
    idle(30);
    if (got_q.size() == 2) chk("b2b_spacing", got_q[1].t - got_q[0].t, 176);
    else chk("b2b_count", got_q.size(), 2);
    check_frames("b2b");

    for (int k = 0; k < 10; k++) begin
      logic [7:0] d;
      logic p, s;
      d = 8'($urandom_range(0, 255));
      p = 1'($urandom_range(0, 1));
      s = ($urandom_range(0, 3) != 0);
      send_frame(d, p, s);
      idle(s ? $urandom_range(0, 30) : 20 + $urandom_range(0, 10));
    end
    check_frames("rand");

    send_frame(8'hFF, 1'b1, 1'b0);
    idle(20);
    check_frames("pre_rst");

    // Abort 0x77 in the middle of data bit 4, then receive 0x12 cleanly.
    begin
      logic [10:0] bits;
      bits = {1'b1, 1'b0, 8'h77, 1'b0};
      for (int i = 0; i < 5 * 16 + 8; i++) begin
        rx_in = bits[i / 16];
        @(negedge clk);
      end
    end
    reset = 1'b0;
    @(negedge clk);
    chk("mid_rst_dout", dout, 8'h00);
    chk("mid_rst_valid", valid, 1'b0);
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_flags", {parity_out, parity_err, frame_err}, 3'b000);
    rx_in = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    idle(20);
    send_frame(8'h12, 1'b0, 1'b1);
    check_frames("post_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
